hamming_serial_encoder: RTL

//  Serial-in, block-out Hamming encoder for the OFDM transmit chain, sitting between the bit

---
 rtl/ofdm_code_pkg.sv | 47 ++++
 rtl/hamming_parity_gen.sv | 43 ++++
 rtl/hamming_serial_encoder.sv | 83 ++++++++
 3 files changed

// File: rtl/ofdm_code_pkg.sv
// Shared Hamming code helpers for the OFDM transmit chain.
// Position/index mapping and size derivation used by encoder and decoder.
package ofdm_code_pkg;

  function automatic int ham_n(input int m);
    return (1 << m) - 1;
  endfunction

  function automatic int ham_k(input int m);
    return ham_n(m) - m;
  endfunction

  function automatic bit ham_is_pow2(input int i);
    return (i > 0) && ((i & (i - 1)) == 0);
  endfunction

  // k-th non-power-of-2 position, counting from 0 (k=0 -> 3)
  function automatic int ham_data_pos(input int k);
    int c;
    int r;
    c = 0;
    r = 0;
    for (int i = 1; i < 4096; i++) begin
      if (!ham_is_pow2(i)) begin
        if (c == k && r == 0) r = i;
        c++;
      end
    end
    return r;
  endfunction

  // data index held at a non-power-of-2 position p
  function automatic int ham_data_idx(input int p);
    int c;
    c = 0;
    for (int i = 1; i < p; i++)
      if (!ham_is_pow2(i)) c++;
    return c;
  endfunction

  function automatic int ham_cntw(input int m);
    int k;
    k = ham_k(m);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming codeword builder: K data bits -> N+1 bit word.
// Ports: d (K data, d[0] first), cw (bit i = position i, bit 0 = ext parity).
module hamming_parity_gen
  import ofdm_code_pkg::*;
#(
  parameter int M          = 3,
  parameter int EXT_PARITY = 1,
  localparam int N         = ham_n(M),
  localparam int K         = ham_k(M)
) (
  input  logic [K-1:0] d,
  output logic [N:0]   cw
);

  logic [N:1] body;
  logic       ext;

  for (genvar i = 1; i <= N; i++) begin : g_pos
    if (!ham_is_pow2(i)) begin : g_d
      assign body[i] = d[ham_data_idx(i)];
    end else begin : g_p
      localparam int J = $clog2(i);
      logic [N:0] t;
      for (genvar q = 0; q <= N; q++) begin : g_t
        if (q > 0 && !ham_is_pow2(q) && ((q >> J) & 1) == 1) begin : g_on
          assign t[q] = d[ham_data_idx(q)];
        end else begin : g_off
          assign t[q] = 1'b0;
        end
      end
      assign body[i] = ^t;
    end
  end

  if (EXT_PARITY != 0) begin : g_x
    assign ext = ^body;
  end else begin : g_z
    assign ext = 1'b0;
  end

  assign cw = {body, ext};

endmodule

// File: rtl/hamming_serial_encoder.sv
// Serial-in, block-out Hamming encoder with a one-word output buffer.
// Ports: clk, reset(async low), clr, in_bit/in_valid/in_ready, cw_data/cw_valid/cw_ready, busy.
module hamming_serial_encoder
  import ofdm_code_pkg::*;
#(
  parameter int M          = 3,
  parameter int EXT_PARITY = 1,
  localparam int N         = ham_n(M),
  localparam int K         = ham_k(M),
  localparam int CW        = ham_cntw(M)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [N:0] cw_data,
  output logic       cw_valid,
  input  logic       cw_ready,
  output logic       busy
);

  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [CW-1:0] count;
  logic [K-2:0]  col;
  logic [K-1:0]  word;
  logic [N:0]    cw_next;
  logic          last;
  logic          acc;
  logic          done;

  assign last = (count == LAST);

  // only the word-completing bit waits for a free output buffer
  assign in_ready = !(last && cw_valid && !cw_ready);
  assign acc      = in_valid && in_ready;
  assign done     = acc && last && !clr;
  assign busy     = (count != '0);

  // the completing bit joins the word without passing through col
  assign word = {in_bit, col};

  hamming_parity_gen #(
    .M          (M),
    .EXT_PARITY (EXT_PARITY)
  ) u_gen (
    .d  (word),
    .cw (cw_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      col   <= '0;
    end else if (clr) begin
      count <= '0;
      col   <= '0;
    end else if (acc) begin
      if (last) begin
        count <= '0;
        col   <= '0;
      end else begin
        count      <= count + CW'(1);
        col[count] <= in_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cw_data  <= '0;
      cw_valid <= 1'b0;
    end else if (done) begin
      cw_data  <= cw_next;
      cw_valid <= 1'b1;
    end else if (cw_ready) begin
      cw_valid <= 1'b0;
    end
  end

endmodule
